// File: rtl/f4_sched_pkg.sv
// f4_sched_pkg: state and op encodings shared by the f4 scheduler and its logic unit.
package f4_sched_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic OP_AND = 1'b1;
   localparam logic OP_OR  = 1'b0;
endpackage

// File: rtl/f4_unit.sv
// f4_unit: combinational W-bit selectable logic unit (AND when chave=OP_AND, else OR).
module f4_unit
   import f4_sched_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         chave,
   output logic [W-1:0] s
);
   always_comb s = (chave == OP_AND) ? (a & b) : (a | b);
endmodule

// File: rtl/f4_sched.sv
// f4_sched: two-requester scheduler for one shared f4_unit (IDLE -> EXEC -> DONE).
// Define F4_ROUND_ROBIN_EN for last-served tie-break; otherwise requester 0 has fixed priority.
module f4_sched
   import f4_sched_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   input  logic         chave0,
   input  logic         chave1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] result,
   output logic         busy
);
   logic [1:0]   state;
   logic         owner;
   logic         win;
   logic         sel;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic [W-1:0] s;

`ifdef F4_ROUND_ROBIN_EN
   logic last;
   assign win = (req0 && req1) ? ~last : ~req0;
   always_ff @(posedge clk)
      if (reset) last <= 1'b1;
      else if (state == ST_DONE) last <= owner;
`else
   assign win = ~req0;
`endif

   f4_unit #(.W(W)) u_unit (.a(opa), .b(opb), .chave(sel), .s(s));

   always_ff @(posedge clk)
      if (reset) begin
         state  <= ST_IDLE;
         owner  <= 1'b0;
         sel    <= OP_OR;
         opa    <= '0;
         opb    <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (req0 || req1) begin
                  owner <= win;
                  opa   <= win ? a1 : a0;
                  opb   <= win ? b1 : b0;
                  sel   <= win ? chave1 : chave0;
                  state <= ST_EXEC;
               end
            ST_EXEC: begin
               result <= s;
               state  <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end

   // Outputs decode registered state/owner only, so req never reaches gnt combinationally.
   assign busy  = state != ST_IDLE;
   assign gnt0  = busy && !owner;
   assign gnt1  = busy && owner;
   assign done0 = (state == ST_DONE) && !owner;
   assign done1 = (state == ST_DONE) && owner;
endmodule

// File: tb/tb_f4_sched.sv
// tb_f4_sched: directed scoreboard bench; expected {owner,result} pushed at issue, popped on each done pulse.
module tb_f4_sched;
   localparam int W = 4;
   logic         clk = 1'b0;
   logic         reset, req0, req1, chave0, chave1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         gnt0, gnt1, done0, done1, busy;
   logic [W-1:0] result;
   logic [W:0]   exp_q[$];
   int           vectors = 0;
   int           errors = 0;

   f4_sched #(.W(W)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .chave0(chave0), .chave1(chave1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", n, act, exp);
      end
   endtask

   // Monitor: each done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (gnt0 && gnt1) begin
         errors++;
         $display("FAIL gnt_excl: gnt0 and gnt1 both high");
      end
      if (done0 || done1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done0=%b done1=%b result=%b", done0, done1, result);
         end else begin
            logic [W:0] e;
            logic [7:0] act, exp;
            e = exp_q.pop_front();
            act = {done0, done1, gnt0, gnt1, result};
            exp = {~e[W], e[W], ~e[W], e[W], e[W-1:0]};
            if (act !== exp) begin
               errors++;
               $display("FAIL done_result: got {d0,d1,g0,g1,res}=%b expected %b", act, exp);
            end
         end
      end
   end

   initial begin
      logic [1:0] order[4];
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
      a0 = 4'b1100; b0 = 4'b1010; chave0 = 1'b1;
      a1 = 4'b1100; b1 = 4'b0011; chave1 = 1'b0;
      cyc();
      cyc();
      chk("reset_outs", {gnt0, gnt1, done0, done1, busy, 3'b0}, 8'h00);
      chk("reset_result", {4'b0, result}, 8'h00);

      // first tie after reset goes to requester 0
      reset = 1'b0;
      exp_q.push_back({1'b0, 4'b1000});
      cyc();
      chk("first_grant", {4'b0, gnt0, gnt1, done0, busy}, 8'b0000_1001);
      req1 = 1'b0;
      cyc();
      chk("and_done", {done0, done1, gnt0, 1'b0, result}, {4'b1010, 4'b1000});
      req0 = 1'b0;
      cyc();
      chk("and_idle", {busy, gnt0, done0, 1'b0, result}, {4'b0000, 4'b1000});

      // OR path for requester 1
      req1 = 1'b1;
      exp_q.push_back({1'b1, 4'b1111});
      cyc();
      chk("or_grant", {6'b0, gnt0, gnt1}, 8'b01);
      cyc();
      chk("or_done", {done0, done1, 2'b0, result}, {4'b0100, 4'b1111});
      req1 = 1'b0;
      cyc();
      chk("or_idle_hold", {busy, 3'b0, result}, {4'b0000, 4'b1111});

      // contention: both held 12 cycles
      a0 = 4'b0110; b0 = 4'b0011; chave0 = 1'b1;
      a1 = 4'b0110; b1 = 4'b1000; chave1 = 1'b0;
`ifdef F4_ROUND_ROBIN_EN
      order = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
      order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      for (int i = 0; i < 4; i++)
         exp_q.push_back(order[i][0] ? {1'b1, 4'b1110} : {1'b0, 4'b0010});
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         chk($sformatf("contend_done_c%0d", i), {7'b0, done0 | done1}, {7'b0, (i % 3) == 2});
      end
      req0 = 1'b0; req1 = 1'b0;

      // operands and req changed after grant
      a0 = 4'b1100; b0 = 4'b1010; chave0 = 1'b1; req0 = 1'b1;
      exp_q.push_back({1'b0, 4'b1000});
      cyc();
      chk("late_grant", {6'b0, gnt0, gnt1}, 8'b10);
      a0 = 4'b0000; chave0 = 1'b0; req0 = 1'b0;
      cyc();
      chk("late_done", {done0, 3'b0, result}, {4'b1000, 4'b1000});
      cyc();
      chk("late_idle", {7'b0, busy}, 8'h00);

      // reset during EXEC aborts silently
      a0 = 4'b1111; b0 = 4'b1111; req0 = 1'b1;
      cyc();
      chk("mid_exec", {6'b0, gnt0, busy}, 8'b11);
      reset = 1'b1; req0 = 1'b0;
      cyc();
      chk("mid_reset", {gnt0, gnt1, done0, done1, busy, 3'b0}, 8'h00);
      chk("mid_reset_result", {4'b0, result}, 8'h00);
      reset = 1'b0;
      cyc();
      cyc();
      chk("after_reset_idle", {done0, done1, busy, 5'b0}, 8'h00);
      chk("queue_drained", 8'(exp_q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
